bnn_layer_sequencer: RTL and testbench

Sequencer for one binary (XNOR/popcount) neuron unit: accepts one 32-bit binarised input word, then time-multiplexes the neuron across `NEURON_COUNT` output neurons. For each neuron it fetches the weight word from a synchronous weight RAM, loads it into the neuron, fires the input, and collects the 1-bit activation. It returns the packed activation vector through a valid/ready handshake. It sits between the layer input FIFO and the next layer, and is wired alongside the neuron unit in the parent `bnn_layer`.

---
 rtl/bnn_pkg.sv | 22 ++
 rtl/bnn_layer_sequencer.sv | 139 +++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary neural-network layer blocks.
package bnn_pkg;

  localparam int unsigned WEIGHT_COUNT_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

  // Address width for a neuron count, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexes one XNOR/popcount neuron across NEURON_COUNT outputs:
// weight fetch, weight load and evaluate overlap so one neuron retires per cycle.
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int unsigned WEIGHT_COUNT = WEIGHT_COUNT_DEFAULT,
  parameter int unsigned NEURON_COUNT = 16,
  parameter int unsigned ADDR_W       = addr_width(NEURON_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WEIGHT_COUNT-1:0] in_pixels,
  output logic                    wmem_rd_en,
  output logic [ADDR_W-1:0]       wmem_addr,
  input  logic [WEIGHT_COUNT-1:0] wmem_rd_data,
  output logic                    nu_weight_wr,
  output logic [WEIGHT_COUNT-1:0] nu_weight_in,
  output logic                    nu_input_plugin,
  output logic [WEIGHT_COUNT-1:0] nu_pixels_in,
  input  logic                    nu_ready_out,
  input  logic                    nu_result_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NEURON_COUNT-1:0] out_bits,
  output logic                    busy
);

  // One extra bit so the counters can hold NEURON_COUNT itself.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NEURON_COUNT - 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(NEURON_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_t              state_q, state_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        cap_cnt_q, cap_cnt_d;
  logic                    wr_q, wr_d;
  logic                    plug_q, plug_d;
  logic [NEURON_COUNT-1:0] out_bits_q, out_bits_d;
  logic [WEIGHT_COUNT-1:0] pixels_q, pixels_d;
  logic                    capture_s;

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      wr_q        <= 1'b0;
      plug_q      <= 1'b0;
      out_bits_q  <= '0;
      pixels_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      wr_q        <= wr_d;
      plug_q      <= plug_d;
      out_bits_q  <= out_bits_d;
      pixels_q    <= pixels_d;
    end
  end

  // Next-state, pipeline shift and result capture.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    out_bits_d  = out_bits_q;
    pixels_d    = pixels_q;
    wr_d        = (state_q == RUN);
    plug_d      = wr_q;

    // Results are only meaningful while a vector is in flight.
    capture_s = nu_ready_out && ((state_q == RUN) || (state_q == DRAIN))
                && (cap_cnt_q < N_CNT);

    if (capture_s) begin
      out_bits_d[cap_cnt_q[ADDR_W-1:0]] = nu_result_out;
      cap_cnt_d = cap_cnt_q + CNT_ONE;
    end else begin
      cap_cnt_d = cap_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pixels_d    = in_pixels;
          out_bits_d  = '0;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        issue_cnt_d = issue_cnt_q + CNT_ONE;
        if (issue_cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // Look at the post-capture count so OUT starts right after the last result.
        if (cap_cnt_d == N_CNT) begin
          state_d = OUT;
        end else begin
          state_d = DRAIN;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready        = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign out_valid       = (state_q == OUT);
  assign out_bits        = out_bits_q;
  assign wmem_rd_en      = (state_q == RUN);
  assign wmem_addr       = issue_cnt_q[ADDR_W-1:0];
  assign nu_weight_wr    = wr_q;
  assign nu_weight_in    = wmem_rd_data;
  assign nu_input_plugin = plug_q;
  assign nu_pixels_in    = pixels_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Scoreboard bench for bnn_layer_sequencer with a 1-cycle RAM and a neuron model.
module tb_bnn_layer_sequencer;
  import bnn_pkg::*;

  localparam int WC = 32;
  localparam int NC = 4;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WC-1:0] in_pixels = '0;
  logic          wmem_rd_en;
  logic [AW-1:0] wmem_addr;
  logic [WC-1:0] wmem_rd_data = '0;
  logic          nu_weight_wr;
  logic [WC-1:0] nu_weight_in;
  logic          nu_input_plugin;
  logic [WC-1:0] nu_pixels_in;
  logic          nu_ready_out;
  logic          nu_result_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NC-1:0] out_bits;
  logic          busy;

  bnn_layer_sequencer #(.WEIGHT_COUNT(WC), .NEURON_COUNT(NC)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .wmem_rd_data(wmem_rd_data),
    .nu_weight_wr(nu_weight_wr), .nu_weight_in(nu_weight_in),
    .nu_input_plugin(nu_input_plugin), .nu_pixels_in(nu_pixels_in),
    .nu_ready_out(nu_ready_out), .nu_result_out(nu_result_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Activation: more matching bits than half; an exact tie follows the weight sign bit.
  function automatic logic act(input logic [WC-1:0] p, input logic [WC-1:0] w);
    int pop;
    pop = $countones(~(p ^ w));
    return (pop > WC/2) || ((pop == WC/2) && w[WC-1]);
  endfunction

  logic [WC-1:0] wmem [NC];

  always @(posedge clock) if (wmem_rd_en) wmem_rd_data <= wmem[wmem_addr];

  logic [WC-1:0] nm_w = '0;
  logic          nm_ready = 1'b0;
  logic          nm_result = 1'b0;
  logic          force_ready = 1'b0;
  logic          force_result = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      nm_ready  <= 1'b0;
      nm_result <= 1'b0;
      nm_w      <= '0;
    end else begin
      if (nu_weight_wr) nm_w <= nu_weight_in;
      nm_ready <= nu_input_plugin;
      if (nu_input_plugin) nm_result <= act(nu_pixels_in, nm_w);
    end
  end

  assign nu_ready_out  = nm_ready | force_ready;
  assign nu_result_out = nm_result | force_result;

  logic [NC-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int acc_cyc = -100;
  int hs_cyc = -100;
  int hs_count = 0;
  int rd_cnt = 0;
  bit rand_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [NC-1:0] expect_vec(input logic [WC-1:0] p);
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = act(p, wmem[i]);
    return v;
  endfunction

  // Monitor: reads, latency, handshake results, re-accept readiness.
  bit prev_ov = 1'b0;
  bit prev_hs = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_ov = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) check("ready_after_hs", 64'(in_ready), 64'd1);
        if (wmem_rd_en) begin
          check("rd_addr", 64'(wmem_addr), 64'(cyc - acc_cyc - 1));
          rd_cnt++;
        end
        if (out_valid && !prev_ov) check("ov_latency", 64'(cyc - acc_cyc), 64'(NC + 4));
        prev_hs = out_valid && out_ready;
        if (out_valid && out_ready) begin
          check("rd_count", 64'(rd_cnt), 64'(NC));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got out_bits %0h with no expected vector", out_bits);
          end else begin
            check("out_bits", 64'(out_bits), 64'(exp_q.pop_front()));
          end
          hs_cyc = cyc;
          hs_count++;
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [WC-1:0] pix, input bit chk_b2b);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    @(posedge clock);
    #1;
    in_valid  = 1'b1;
    in_pixels = pix;
    while (!done && n < 300) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        acc_cyc = cyc - 1;
        rd_cnt  = 0;
        exp_q.push_back(expect_vec(pix));
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        n++;
      end
    end
    in_valid = 1'b0;
    check("accept_timeout", 64'(done), 64'd1);
    if (done) begin
      check("pixels_latched", 64'(nu_pixels_in), 64'(pix));
      if (chk_b2b) check("b2b_gap", 64'(acc_cyc - hs_cyc), 64'd1);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (hs_count < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("done_timeout", 64'(hs_count >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] held;
    int n;
    wmem[0] = 32'hFFFF_FFFF;
    wmem[1] = 32'h0000_0000;
    wmem[2] = 32'hFFFF_0000;
    wmem[3] = 32'h0000_FFFF;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bits", 64'(out_bits), 64'd0);
    check("rst_rd_en", 64'(wmem_rd_en), 64'd0);
    check("rst_addr", 64'(wmem_addr), 64'd0);
    check("rst_wr", 64'(nu_weight_wr), 64'd0);
    check("rst_plugin", 64'(nu_input_plugin), 64'd0);
    check("rst_pixels", 64'(nu_pixels_in), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    send(32'hFFFF_0000, 1'b0);
    wait_done(1);
    check("single_const", 64'(out_bits), 64'h5);

    @(posedge clock);
    #1;
    out_ready = 1'b0;
    send(32'h0F0F_3C3C, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    held = out_bits;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_bits", 64'(out_bits), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_no_read", 64'(wmem_rd_en), 64'd0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_done(2);

    send(32'hAAAA_AAAA, 1'b0);
    send(32'h5555_5555, 1'b1);
    wait_done(4);

    send(32'h1234_5678, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_out_bits", 64'(out_bits), 64'd0);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_wr", 64'(nu_weight_wr), 64'd0);
    check("mrst_plugin", 64'(nu_input_plugin), 64'd0);
    check("mrst_pixels", 64'(nu_pixels_in), 64'd0);

    @(posedge clock);
    #1;
    force_ready  = 1'b1;
    force_result = 1'b1;
    @(posedge clock);
    #1;
    force_ready  = 1'b0;
    force_result = 1'b0;
    @(negedge clock);
    check("spur_bits", 64'(out_bits), 64'd0);
    check("spur_in_ready", 64'(in_ready), 64'd1);
    check("spur_busy", 64'(busy), 64'd0);

    send(32'hFFFF_0000, 1'b0);
    wait_done(5);
    check("post_rst_const", 64'(out_bits), 64'h5);

    rand_bp = 1'b1;
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < NC; i++) wmem[i] = $urandom;
      send($urandom, 1'b0);
      wait_done(6 + v);
    end
    rand_bp = 1'b0;
    @(posedge clock);
    #1;
    out_ready = 1'b1;

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
